cart_detect: RTL

- Snoops the HPS ROM download stream (ioctl_*) in parallel with the ROM dpram write port.
- Determines the cartridge bank-switch scheme, the SuperChip enable and the ROM size, and feeds them to A2601top as force_bs, sc and rom_size.
- Replaces the inline extension-only latch in the emu top. Extension overrides still take priority; otherwise the scheme comes from content signatures and image size.

---
 rtl/cart_pkg.sv | 38 +++
 rtl/cart_sig_match.sv | 35 +++
 rtl/cart_detect.sv | 156 +++++++++++++++
 3 files changed

// File: rtl/cart_pkg.sv
// Shared types and constants for 2600 cartridge scheme detection.
// Latency: n/a (types, constants and one helper function only).
// Backpressure: n/a.
//   bs_t    : bank-switch scheme codes understood by A2601top
//   state_t : detector phases
//   EXT_*   : low 24 bits of ioctl_file_ext for forcing extensions
package cart_pkg;

  typedef enum logic [2:0] {
    BS_NONE = 3'd0,
    BS_FE   = 3'd3,
    BS_E0   = 3'd4,
    BS_3F   = 3'd5,
    BS_P2   = 3'd7
  } bs_t;

  typedef enum logic [1:0] {
    IDLE,
    LOAD,
    DECIDE,
    DONE
  } state_t;

  // ASCII ".E0", ".FE", ".3F", ".P2"
  localparam logic [23:0] EXT_E0 = 24'h2E4530;
  localparam logic [23:0] EXT_FE = 24'h2E4645;
  localparam logic [23:0] EXT_3F = 24'h2E3346;
  localparam logic [23:0] EXT_P2 = 24'h2E5032;

  localparam logic [16:0] ROM_8K  = 17'd8192;
  localparam logic [16:0] ROM_MAX = 17'h1FFFF;

  // 4-bit counter step that sticks at 15
  function automatic logic [3:0] sat_inc4(input logic [3:0] c, input logic en);
    return (en && (c != 4'hF)) ? c + 4'd1 : c;
  endfunction

endpackage

// File: rtl/cart_sig_match.sv
// Matches bank-switch code signatures on a 3-byte download window.
// Latency: combinational; hits are valid in the same cycle as vld.
// Backpressure: none; one pulse per vld cycle per matching signature.
//   vld        : window was updated on the previous clock edge
//   w2, w1, w0 : oldest .. newest byte of the window
//   hit_3f/e0/fe : one-cycle match pulses
module cart_sig_match
  import cart_pkg::*;
(
  input  logic       vld,
  input  logic [7:0] w2,
  input  logic [7:0] w1,
  input  logic [7:0] w0,
  output logic       hit_3f,
  output logic       hit_e0,
  output logic       hit_fe
);

  always_comb begin
    hit_3f = 1'b0;
    hit_e0 = 1'b0;
    hit_fe = 1'b0;
    if (vld) begin
      // STA $3F: bank select write for 3F carts
      hit_3f = (w1 == 8'h85) && (w0 == 8'h3F);
      // LDA/STA/NOP abs $1FE0-$1FE7: E0 slice hotspots
      hit_e0 = ((w2 == 8'h8D) || (w2 == 8'hAD) || (w2 == 8'h0C)) &&
               (w1[7:3] == 5'b11100) && (w0 == 8'h1F);
      // JSR $D000 / $F000: FE bank flip via stack access
      hit_fe = (w2 == 8'h20) && (w1 == 8'h00) &&
               ((w0 == 8'hD0) || (w0 == 8'hF0));
    end
  end

endmodule

// File: rtl/cart_detect.sv
// Snoops the HPS ROM download and picks bank scheme, SuperChip and ROM size.
// Latency: force_bs/sc/detect_valid settle 2 cycles after download falls.
// Backpressure: none; passive observer of ioctl_* and never stalls the load.
//   in : clk_sys, reset_n (sync, active low), ioctl_download/wr/addr/dout,
//        ioctl_file_ext ([23:0] used), sc_option
//   out: force_bs, sc, rom_size (live byte count), detect_valid
module cart_detect
  import cart_pkg::*;
#(
  parameter int SIG_MIN_3F = 2,
  parameter int SIG_MIN_E0 = 1,
  parameter int SIG_MIN_FE = 1
) (
  input  logic        clk_sys,
  input  logic        reset_n,
  input  logic        ioctl_download,
  input  logic        ioctl_wr,
  input  logic [24:0] ioctl_addr,
  input  logic [7:0]  ioctl_dout,
  input  logic [31:0] ioctl_file_ext,
  input  logic        sc_option,
  output logic [2:0]  force_bs,
  output logic        sc,
  output logic [16:0] rom_size,
  output logic        detect_valid
);

  state_t      state, state_nxt;
  logic        dl_q, dl_rise, dl_fall, load_start, wr_en, addr_gap;
  logic [7:0]  w2, w1, w0, byte0;
  logic [24:0] prev_addr;
  logic        first_wr, sc_auto, sig_vld;
  logic [3:0]  h3f, he0, hfe, h3f_nxt, he0_nxt, hfe_nxt;
  logic        hit_3f, hit_e0, hit_fe;
  logic [23:0] ext_q;
  bs_t         bs_dec;
  logic        sc_dec;
  logic        unused_ext;

  assign unused_ext = ^ioctl_file_ext[31:24];

  assign dl_rise    = ioctl_download & ~dl_q;
  assign dl_fall    = ~ioctl_download & dl_q;
  assign load_start = dl_rise & ((state == IDLE) | (state == DONE));
  assign wr_en      = (state == LOAD) & ioctl_wr;
  assign addr_gap   = ~first_wr & (ioctl_addr != prev_addr + 25'd1);

  // Counts including the pulse in flight, so a hit from the final byte
  // (written in the same cycle the download fell) still reaches DECIDE.
  assign h3f_nxt = sat_inc4(h3f, hit_3f);
  assign he0_nxt = sat_inc4(he0, hit_e0);
  assign hfe_nxt = sat_inc4(hfe, hit_fe);

  cart_sig_match u_sig (
    .vld    (sig_vld),
    .w2     (w2),
    .w1     (w1),
    .w0     (w0),
    .hit_3f (hit_3f),
    .hit_e0 (hit_e0),
    .hit_fe (hit_fe)
  );

  always_ff @(posedge clk_sys) begin
    if (!reset_n) state <= IDLE;
    else          state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:    if (dl_rise) state_nxt = LOAD;
      LOAD:    if (dl_fall) state_nxt = DECIDE;
      DECIDE:  state_nxt = DONE;
      DONE:    if (dl_rise) state_nxt = LOAD;
      default: state_nxt = IDLE;
    endcase
  end

  always_comb begin
    bs_dec = BS_NONE;
    if      (ext_q == EXT_E0) bs_dec = BS_E0;
    else if (ext_q == EXT_FE) bs_dec = BS_FE;
    else if (ext_q == EXT_3F) bs_dec = BS_3F;
    else if (ext_q == EXT_P2) bs_dec = BS_P2;
    else if (int'(h3f_nxt) >= SIG_MIN_3F) bs_dec = BS_3F;
    else if ((rom_size == ROM_8K) && (int'(he0_nxt) >= SIG_MIN_E0)) bs_dec = BS_E0;
    else if ((rom_size == ROM_8K) && (int'(hfe_nxt) >= SIG_MIN_FE)) bs_dec = BS_FE;
    sc_dec = sc_option | (sc_auto & (rom_size >= ROM_8K));
  end

  always_ff @(posedge clk_sys) begin
    if (!reset_n) begin
      // Treat download as already high so a load in progress across reset
      // release is not mistaken for a fresh start.
      dl_q         <= 1'b1;
      w2           <= 8'h00;
      w1           <= 8'h00;
      w0           <= 8'h00;
      byte0        <= 8'h00;
      prev_addr    <= '0;
      first_wr     <= 1'b1;
      sc_auto      <= 1'b0;
      sig_vld      <= 1'b0;
      h3f          <= 4'd0;
      he0          <= 4'd0;
      hfe          <= 4'd0;
      ext_q        <= 24'h0;
      rom_size     <= '0;
      force_bs     <= BS_NONE;
      sc           <= 1'b0;
      detect_valid <= 1'b0;
    end else begin
      dl_q    <= ioctl_download;
      sig_vld <= wr_en;
      h3f     <= h3f_nxt;
      he0     <= he0_nxt;
      hfe     <= hfe_nxt;
      if (load_start) begin
        w2           <= 8'h00;
        w1           <= 8'h00;
        w0           <= 8'h00;
        byte0        <= 8'h00;
        first_wr     <= 1'b1;
        sc_auto      <= 1'b1;
        h3f          <= 4'd0;
        he0          <= 4'd0;
        hfe          <= 4'd0;
        ext_q        <= ioctl_file_ext[23:0];
        rom_size     <= '0;
        force_bs     <= BS_NONE;
        sc           <= 1'b0;
        detect_valid <= 1'b0;
      end else if (wr_en) begin
        if (rom_size != ROM_MAX) rom_size <= rom_size + 17'd1;
        // Non-sequential address: older bytes are not adjacent in the ROM
        w2        <= addr_gap ? 8'h00 : w1;
        w1        <= addr_gap ? 8'h00 : w0;
        w0        <= ioctl_dout;
        prev_addr <= ioctl_addr;
        first_wr  <= 1'b0;
        // SuperChip images carry a uniform fill in the first page (RAM area)
        if (ioctl_addr == 25'd0)
          byte0 <= ioctl_dout;
        else if ((ioctl_addr < 25'h100) && (ioctl_dout != byte0))
          sc_auto <= 1'b0;
      end
      if (state == DECIDE) begin
        force_bs     <= bs_dec;
        sc           <= sc_dec;
        detect_valid <= 1'b1;
      end
    end
  end

endmodule
